bus_debug_master: RTL and testbench
===================================

BUS_DEBUG_MASTER -- requirements
Module: bus_debug_master

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 24'd1000000, SHALL set the inter-byte timeout in clk cycles while a command frame is partially received.
REQ-002 Parameter OP_WRITE, default 8'h57 ('W'), SHALL be the write opcode.
REQ-003 Parameter OP_READ, default 8'h52 ('R'), SHALL be the read opcode.
REQ-004 clk  input  1  system clock; all logic SHALL be on posedge clk.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 rx_data  input  8  byte from UART receiver; valid only when rx_valid=1.
REQ-007 rx_valid  input  1  one-cycle pulse per received byte.
REQ-008 tx_data  output  8  response byte to UART sender.
REQ-009 tx_start  output  1  transmit request for tx_data.
REQ-010 tx_busy  input  1  sender busy flag.
REQ-011 bus_req  output  1  request for peripheral-bus ownership.
REQ-012 bus_gnt  input  1  bus ownership grant.
REQ-013 MemRead  output  1  bus read strobe.
REQ-014 MemWrite  output  1  bus write strobe.
REQ-015 Address  output  32  bus address.
REQ-016 Write_data  output  32  bus write data.
REQ-017 Read_data  input  32  bus read data, combinationally valid while MemRead=1.
REQ-018 frame_err  output  1  one-cycle pulse on bad opcode or timeout.

Function
REQ-019 States SHALL be IDLE, ADDR, DATA, REQ, ACCESS, RESP, NAK.
REQ-020 IDLE: rx_valid with OP_WRITE or OP_READ -> ADDR, opcode latched; any other byte -> NAK with frame_err pulse.
REQ-021 ADDR SHALL collect 4 bytes MSB-first into Address; 4th byte -> DATA for write, REQ for read.
REQ-022 DATA SHALL collect 4 bytes MSB-first into Write_data; 4th byte -> REQ.
REQ-023 In ADDR/DATA, a 2-bit byte counter SHALL reset to 0 on entry and wrap 3->0 on the last byte.
REQ-024 In ADDR/DATA, IDLE_TIMEOUT consecutive cycles without rx_valid SHALL return to IDLE, discard the partial frame, pulse frame_err, send nothing.
REQ-025 bus_req SHALL be 1 exactly in states REQ and ACCESS.
REQ-026 REQ -> ACCESS on the cycle after bus_gnt=1 is sampled; wait for grant SHALL be unbounded.
REQ-027 ACCESS SHALL last exactly one cycle with MemWrite=1 (write) or MemRead=1 (read), never both; Address/Write_data stable throughout.
REQ-028 Read: Read_data SHALL be captured at the end of the ACCESS cycle.
REQ-029 RESP: write sends one byte 8'h4B ('K'); read sends 4 bytes, captured data MSB-first.
REQ-030 NAK sends one byte 8'h3F ('?'), then IDLE.
REQ-031 TX handshake: tx_start SHALL rise only when tx_busy=0, hold with tx_data stable until tx_busy=1 is sampled, then drop; next byte only after tx_busy returns to 0.
REQ-032 After the last response byte's tx_busy falls, state SHALL return to IDLE the following cycle.
REQ-033 rx_valid in REQ, ACCESS, RESP, NAK SHALL be ignored (byte dropped).
REQ-034 rx_valid on the same cycle a timeout expires: timeout SHALL win, byte dropped.
REQ-035 Latency: final command byte at cycle N with bus_gnt=1 held -> REQ at N+1, ACCESS at N+2, first tx_start at N+3.

Reset
REQ-036 On reset=0 all outputs SHALL be 0 (tx_data 8'h00, Address/Write_data 32'h0), state IDLE, counters 0, asynchronously.
REQ-037 Reset mid-ACCESS SHALL drop MemRead/MemWrite immediately; no response byte sent after release.

Structure
REQ-038 Shared package SHALL hold state encoding, ACK/NAK byte constants, and default opcodes.
REQ-039 One sub-module, resp_serializer, SHALL implement REQ-031 for up to 4 bytes; command parser and bus FSM stay in the top.

Verification
REQ-040 Bytes 57 40 00 00 0C 00 00 00 A5, bus_gnt=1 -> single MemWrite cycle, Address 32'h4000000C, Write_data 32'h000000A5, then tx byte 4B.
REQ-041 Bytes 52 40 00 00 10, Read_data=32'h0000005A in ACCESS -> one MemRead cycle, tx bytes 00 00 00 5A in order.
REQ-042 Byte 13 -> frame_err pulse, tx byte 3F, no bus strobe.
REQ-043 Bytes 57 40 then silence > IDLE_TIMEOUT (override 16) -> frame_err at cycle 16, no tx, next 52 frame processed normally.
REQ-044 Read frame, bus_gnt held 0 for 50 cycles -> bus_req=1, no strobe; grant -> ACCESS next cycle; tx_busy held 1 for 20 cycles per byte -> tx_start held, tx_data stable.
REQ-045 reset asserted during ACCESS -> MemRead 0 same cycle, no tx_start after release, IDLE accepts new frame.

Source files
------------

// File: rtl/bus_debug_master_pkg.sv
// Shared definitions for the UART-driven bus debug master: FSM state
// encodings, response byte constants and the default command opcodes.
package bus_debug_master_pkg;

  // Command/bus FSM states of the top level
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_REQ    = 3'd3,
    ST_ACCESS = 3'd4,
    ST_RESP   = 3'd5,
    ST_NAK    = 3'd6
  } state_t;

  // Response serializer handshake states
  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_WAIT  = 2'd1,  // byte loaded, waiting for the sender to go idle
    SER_START = 2'd2,  // tx_start asserted, waiting for tx_busy
    SER_HOLD  = 2'd3   // byte accepted, waiting for tx_busy to fall
  } ser_state_t;

  localparam logic [7:0] ACK_BYTE     = 8'h4B;  // 'K'
  localparam logic [7:0] NAK_BYTE     = 8'h3F;  // '?'
  localparam logic [7:0] DEF_OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] DEF_OP_READ  = 8'h52;  // 'R'

endpackage

// File: rtl/resp_serializer.sv
// Sends 1..4 response bytes MSB-first to a UART sender using the
// tx_start / tx_busy handshake. o_done is combinational so the parent can
// leave its response state on the very cycle after the last tx_busy falls.
module resp_serializer
  import bus_debug_master_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,      // one-cycle load request, only honoured when idle
  input  logic [31:0] i_data,      // bytes to send, first byte in [31:24]
  input  logic [1:0]  i_last_idx,  // number of bytes minus one
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        o_done
);

  ser_state_t  r_state;
  logic [23:0] r_shift;
  logic [1:0]  r_left;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;

  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign o_done   = (r_state == SER_HOLD) && !tx_busy && (r_left == 2'd0);

  // Byte-by-byte handshake: raise only when sender idle, drop on busy, next byte after busy falls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= SER_IDLE;
      r_shift    <= 24'h0;
      r_left     <= 2'd0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
    end else begin
      case (r_state)
        SER_IDLE: begin
          if (i_load) begin
            r_shift   <= i_data[23:0];
            r_left    <= i_last_idx;
            r_tx_data <= i_data[31:24];
            if (!tx_busy) begin
              r_tx_start <= 1'b1;
              r_state    <= SER_START;
            end else begin
              r_state <= SER_WAIT;
            end
          end
        end
        SER_WAIT: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_state    <= SER_START;
          end
        end
        SER_START: begin
          if (tx_busy) begin
            r_tx_start <= 1'b0;
            r_state    <= SER_HOLD;
          end
        end
        SER_HOLD: begin
          if (!tx_busy) begin
            if (r_left == 2'd0) begin
              r_state <= SER_IDLE;
            end else begin
              r_tx_data  <= r_shift[23:16];
              r_shift    <= {r_shift[15:0], 8'h00};
              r_left     <= r_left - 2'd1;
              r_tx_start <= 1'b1;
              r_state    <= SER_START;
            end
          end
        end
        default: r_state <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bus_debug_master.sv
// UART command parser and peripheral-bus master. Accepts 'W' addr[4] data[4]
// and 'R' addr[4] frames, performs one bus access after arbitration, and
// answers with 'K', the four read bytes, or '?' for an unknown opcode.
module bus_debug_master
  import bus_debug_master_pkg::*;
#(
  parameter logic [23:0] IDLE_TIMEOUT = 24'd1000000,
  parameter logic [7:0]  OP_WRITE     = DEF_OP_WRITE,
  parameter logic [7:0]  OP_READ      = DEF_OP_READ
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data,
  output logic        frame_err
);

  state_t      r_state;
  logic        r_is_write;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_idle_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_bus_req;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic        r_frame_err;

  logic        w_is_op;
  logic        w_timeout;
  logic        w_ser_load;
  logic [31:0] w_ser_data;
  logic [1:0]  w_ser_last;
  logic        w_ser_done;

  assign w_is_op   = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  // Expiry depends only on the counter, so a byte arriving on the expiry cycle loses
  assign w_timeout = (r_idle_cnt == (IDLE_TIMEOUT - 24'd1));

  // Response is loaded as ACCESS ends (captures Read_data) or as a bad opcode is seen
  assign w_ser_load = (r_state == ST_ACCESS) ||
                      ((r_state == ST_IDLE) && rx_valid && !w_is_op);
  assign w_ser_data = (r_state == ST_ACCESS) ?
                        (r_is_write ? {ACK_BYTE, 24'h0} : Read_data) :
                        {NAK_BYTE, 24'h0};
  assign w_ser_last = ((r_state == ST_ACCESS) && !r_is_write) ? 2'd3 : 2'd0;

  assign bus_req    = r_bus_req;
  assign MemRead    = r_mem_rd;
  assign MemWrite   = r_mem_wr;
  assign Address    = r_addr;
  assign Write_data = r_wdata;
  assign frame_err  = r_frame_err;

  resp_serializer u_ser (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_ser_load),
    .i_data     (w_ser_data),
    .i_last_idx (w_ser_last),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .o_done     (w_ser_done)
  );

  // Command parse, inter-byte timeout, bus arbitration/access and response sequencing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_is_write  <= 1'b0;
      r_byte_cnt  <= 2'd0;
      r_idle_cnt  <= 24'd0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_bus_req   <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (w_is_op) begin
              r_is_write <= (rx_data == OP_WRITE);
              r_byte_cnt <= 2'd0;
              r_idle_cnt <= 24'd0;
              r_state    <= ST_ADDR;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_NAK;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_byte_cnt  <= 2'd0;
            r_idle_cnt  <= 24'd0;
            r_state     <= ST_IDLE;
          end else if (rx_valid) begin
            r_idle_cnt <= 24'd0;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_state == ST_ADDR) begin
              r_addr <= {r_addr[23:0], rx_data};
            end else begin
              r_wdata <= {r_wdata[23:0], rx_data};
            end
            if (r_byte_cnt == 2'd3) begin
              if ((r_state == ST_ADDR) && r_is_write) begin
                r_state <= ST_DATA;
              end else begin
                r_bus_req <= 1'b1;
                r_state   <= ST_REQ;
              end
            end
          end else begin
            r_idle_cnt <= r_idle_cnt + 24'd1;
          end
        end
        ST_REQ: begin
          if (bus_gnt) begin
            r_mem_wr <= r_is_write;
            r_mem_rd <= !r_is_write;
            r_state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_mem_wr  <= 1'b0;
          r_mem_rd  <= 1'b0;
          r_bus_req <= 1'b0;
          r_state   <= ST_RESP;
        end
        ST_RESP, ST_NAK: begin
          if (w_ser_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_debug_master.sv
// Randomized and directed bench for bus_debug_master with a transaction-level
// reference model (frame in -> expected bus operation, response bytes, errors).
module tb_bus_debug_master;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
  } bus_op_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        bus_req;
  logic        bus_gnt;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data = 32'h0;
  logic        frame_err;

  bus_debug_master #(.IDLE_TIMEOUT(24'd16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stimulus knobs
  int          ack_min = 0, ack_max = 0, busy_len = 2;
  bit          gnt_auto = 1'b0;
  int          gnt_dly = 0;
  logic        gnt_manual = 1'b1;
  logic [31:0] rd_val = 32'h0;
  int          last_cyc = 0;

  // Observations
  logic [7:0]  got_tx[$];
  int          tx_cyc[$];
  bus_op_t     got_bus[$];
  bit          snd_active = 1'b0;
  int          req_cnt = 0, req_first = -1, req_cycles = 0, mem_first = -1;
  int          err_cnt = 0, err_cyc = -1;

  // Expectations from the reference model
  logic [7:0]  exp_tx[$];
  bus_op_t     exp_bus[$];
  int          exp_err = 0;

  always_comb bus_gnt = gnt_auto ? (bus_req && (req_cnt >= gnt_dly)) : gnt_manual;

  // UART sender model: accept tx_start after a random delay, then stay busy
  initial begin : sender_proc
    logic [7:0] b;
    int w;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        b = tx_data;
        got_tx.push_back(b);
        tx_cyc.push_back(cyc);
        snd_active = 1'b1;
        w = $urandom_range(ack_max, ack_min);
        repeat (w) begin
          @(negedge clk);
          chk("tx_hold", 64'({tx_start, tx_data}), 64'({1'b1, b}));
        end
        tx_busy = 1'b1;
        repeat (busy_len) begin
          @(negedge clk);
          chk("tx_drop", 64'(tx_start), 64'd0);
        end
        tx_busy = 1'b0;
        snd_active = 1'b0;
      end
    end
  end

  // Bus slave model: record strobes, supply Read_data only during MemRead
  initial begin : bus_proc
    bus_op_t op;
    forever begin
      @(negedge clk);
      if (MemRead || MemWrite) begin
        chk("strobe_excl", 64'(MemRead && MemWrite), 64'd0);
        chk("strobe_req", 64'(bus_req), 64'd1);
        op.wr = MemWrite; op.a = Address; op.d = Write_data;
        got_bus.push_back(op);
        if (mem_first < 0) mem_first = cyc;
      end
      if (bus_req) begin
        req_cnt++;
        req_cycles++;
        if (req_first < 0) req_first = cyc;
      end else begin
        req_cnt = 0;
      end
      Read_data = MemRead ? rd_val : $urandom;
    end
  end

  initial begin : err_proc
    forever begin
      @(negedge clk);
      if (frame_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // Reference model: what one complete frame must produce
  task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd);
    bus_op_t e;
    if (op == 8'h57) begin
      e.wr = 1'b1; e.a = a; e.d = d;
      exp_bus.push_back(e);
      exp_tx.push_back(8'h4B);
    end else if (op == 8'h52) begin
      e.wr = 1'b0; e.a = a; e.d = 32'h0;
      exp_bus.push_back(e);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
    end else begin
      exp_err = 1;
      exp_tx.push_back(8'h3F);
    end
  endtask

  task automatic clear_obs();
    got_tx.delete(); tx_cyc.delete(); got_bus.delete();
    exp_tx.delete(); exp_bus.delete(); exp_err = 0;
    err_cnt = 0; err_cyc = -1;
    req_first = -1; req_cycles = 0; mem_first = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    last_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!((got_tx.size() >= exp_tx.size()) && !snd_active) && (n < 4000)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n >= 4000), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_n_tx"}, 64'(got_tx.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
      chk({tag, "_tx_byte"}, 64'(got_tx[i]), 64'(exp_tx[i]));
    chk({tag, "_n_bus"}, 64'(got_bus.size()), 64'(exp_bus.size()));
    for (int i = 0; i < exp_bus.size() && i < got_bus.size(); i++) begin
      chk({tag, "_bus_wr"}, 64'(got_bus[i].wr), 64'(exp_bus[i].wr));
      chk({tag, "_bus_addr"}, 64'(got_bus[i].a), 64'(exp_bus[i].a));
      if (exp_bus[i].wr) chk({tag, "_bus_wdata"}, 64'(got_bus[i].d), 64'(exp_bus[i].d));
    end
    chk({tag, "_frame_err"}, 64'(err_cnt), 64'(exp_err));
  endtask

  task automatic run_frame(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rd,
                           input int gmin, input int gmax);
    clear_obs();
    rd_val = rd;
    model(op, a, d, rd);
    send_byte(op, 0);
    if (op == 8'h57 || op == 8'h52)
      for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], $urandom_range(gmax, gmin));
    if (op == 8'h57)
      for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], $urandom_range(gmax, gmin));
    wait_done(tag);
    compare(tag);
  endtask

  initial begin : main
    int c, g, r;
    logic [7:0] op;
    logic [31:0] a, d, rd;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({tx_start, bus_req, MemRead, MemWrite, frame_err}), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_addr", 64'(Address), 64'd0);
    chk("rst_wdata", 64'(Write_data), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Write frame with grant held, plus command-to-response latency
    gnt_auto = 1'b0; gnt_manual = 1'b1; ack_min = 0; ack_max = 0; busy_len = 3;
    run_frame("wr", 8'h57, 32'h4000000C, 32'h000000A5, 32'h0, 0, 0);
    chk("lat_req", 64'(req_first - last_cyc), 64'd1);
    chk("lat_access", 64'(mem_first - last_cyc), 64'd2);
    if (tx_cyc.size() > 0) chk("lat_tx", 64'(tx_cyc[0] - last_cyc), 64'd3);
    chk("req_len", 64'(req_cycles), 64'd2);

    // Read frame
    run_frame("rd", 8'h52, 32'h40000010, 32'h0, 32'h0000005A, 0, 2);

    // Bad opcode
    run_frame("bad_op", 8'h13, 32'h0, 32'h0, 32'h0, 0, 0);

    // Inter-byte timeout discards the partial frame
    clear_obs();
    send_byte(8'h57, 0);
    send_byte(8'h40, 0);
    c = last_cyc;
    repeat (40) @(negedge clk);
    chk("to_err_n", 64'(err_cnt), 64'd1);
    chk("to_err_cyc", 64'(err_cyc - c), 64'd17);
    chk("to_no_tx", 64'(got_tx.size()), 64'd0);
    chk("to_no_bus", 64'(got_bus.size()), 64'd0);
    run_frame("after_to", 8'h52, 32'h12345678, 32'h0, 32'hCAFEF00D, 0, 3);

    // Byte on the expiry cycle is dropped; one cycle earlier it is accepted
    clear_obs();
    send_byte(8'h57, 0);
    send_byte(8'h40, 15);
    c = last_cyc;
    repeat (30) @(negedge clk);
    chk("to_edge_err_n", 64'(err_cnt), 64'd1);
    chk("to_edge_err_cyc", 64'(err_cyc - c), 64'd1);
    chk("to_edge_no_tx", 64'(got_tx.size()), 64'd0);
    run_frame("gap14", 8'h52, 32'h89ABCDEF, 32'h0, 32'h01020304, 14, 14);

    // Long grant wait, slow sender, stray byte ignored while waiting
    gnt_manual = 1'b0; ack_min = 20; ack_max = 20; busy_len = 20;
    clear_obs();
    rd_val = 32'hDEADBEEF;
    model(8'h52, 32'h00001000, 32'h0, rd_val);
    send_byte(8'h52, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    repeat (20) @(negedge clk);
    send_byte(8'h13, 0);
    repeat (29) @(negedge clk);
    chk("gw_bus_req", 64'(bus_req), 64'd1);
    chk("gw_no_strobe", 64'(got_bus.size()), 64'd0);
    chk("gw_no_err", 64'(err_cnt), 64'd0);
    gnt_manual = 1'b1;
    g = cyc;
    wait_done("gw");
    compare("gw");
    chk("gw_grant_to_access", 64'(mem_first - g), 64'd1);
    chk("gw_req_len", 64'(req_cycles), 64'(mem_first - req_first + 1));

    // Reset during ACCESS
    ack_min = 0; ack_max = 1; busy_len = 2;
    gnt_manual = 1'b0;
    clear_obs();
    rd_val = 32'h11223344;
    send_byte(8'h52, 0);
    send_byte(8'hA0, 0); send_byte(8'hB0, 0); send_byte(8'hC0, 0); send_byte(8'hD0, 0);
    repeat (5) @(negedge clk);
    gnt_manual = 1'b1;
    @(negedge clk);
    chk("rstacc_memread", 64'(MemRead), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstacc_drop", 64'({MemRead, MemWrite, bus_req}), 64'd0);
    chk("rstacc_addr", 64'(Address), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("rstacc_no_tx", 64'(got_tx.size()), 64'd0);
    chk("rstacc_one_strobe", 64'(got_bus.size()), 64'd1);
    run_frame("rstacc_next", 8'h57, 32'h0000ABCD, 32'h55AA55AA, 32'h0, 0, 1);

    // Randomized frames
    gnt_auto = 1'b1;
    for (int t = 0; t < 40; t++) begin
      gnt_dly  = $urandom_range(6, 0);
      ack_max  = $urandom_range(3, 0);
      ack_min  = 0;
      busy_len = $urandom_range(4, 1);
      r = $urandom_range(9, 0);
      if (r < 4) op = 8'h57;
      else if (r < 8) op = 8'h52;
      else begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
      end
      a = $urandom; d = $urandom; rd = $urandom;
      run_frame("rand", op, a, d, rd, 0, 8);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
